// File: rtl/usb_arb_pkg.sv
// -----------------------------------------------------------------------------
// usb_arb_pkg
// Shared definitions for the USB stream arbiter: FSM state encoding, default
// header tag, header byte-0 field positions and the header length.
// Optional feature macro: USB_ARB_CSUM_EN (adds the CSUM state).
// -----------------------------------------------------------------------------
package usb_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_HDR0,
    ST_HDR1,
`ifdef USB_ARB_CSUM_EN
    ST_DATA,
    ST_CSUM
`else
    ST_DATA
`endif
  } arb_state_e;

  localparam logic [3:0] HDR_TAG = 4'hA;

  // Header byte 0 layout: {tag[7:4], last[3], 1'b0, id[1:0]}
  localparam int HDR_TAG_LSB  = 4;
  localparam int HDR_LAST_BIT = 3;
  localparam int HDR_ID_LSB   = 0;

  // Bytes of framing ahead of the payload.
  localparam int HDR_LEN = 2;

  function automatic logic [7:0] make_hdr0(input logic [3:0] tag,
                                           input logic       last,
                                           input logic [1:0] id);
    logic [7:0] hdr;
    hdr = 8'h00;
    hdr[HDR_TAG_LSB +: 4] = tag;
    hdr[HDR_LAST_BIT]     = last;
    hdr[HDR_ID_LSB +: 2]  = id;
    return hdr;
  endfunction

endpackage

// File: rtl/usb_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// usb_arb_rr_pick
// Combinational round-robin selector: returns the first asserted valid bit
// found searching upward from rr_ptr, wrapping at NUM_SRC.
//   valid     in  NUM_SRC  request vector
//   rr_ptr    in  2        search start index (< NUM_SRC)
//   grant     out 2        selected index (0 when nothing is valid)
//   any_valid out 1        at least one request is pending
// Optional feature macro: USB_ARB_CSUM_EN (not used in this file).
// -----------------------------------------------------------------------------
module usb_arb_rr_pick #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] valid,
  input  logic [1:0]         rr_ptr,
  output logic [1:0]         grant,
  output logic               any_valid
);

  logic found;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    grant     = 2'd0;
    found     = 1'b0;
    any_valid = |valid;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found && valid[(int'(rr_ptr) + k) % NUM_SRC]) begin
        grant = 2'((int'(rr_ptr) + k) % NUM_SRC);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_stream_arbiter.sv
// -----------------------------------------------------------------------------
// usb_stream_arbiter
// Shares one USB byte-stream FIFO sink among up to 4 byte-stream sources.
// A source is granted round-robin, up to MAX_BURST of its bytes are gathered
// into a chunk buffer, and the chunk is sent as a framed packet:
//   {HDR_TAG, last, 0, id}, count, payload[0..count-1] (, checksum)
// Optional feature macro: USB_ARB_CSUM_EN appends an XOR checksum byte over
// both header bytes and the payload.
// Ports:
//   mclk, reset            clock, synchronous active-high reset
//   src_valid/data/last    per-source byte stream (source i at data[8i+7:8i])
//   src_ready              per-source accept (only the granted source, in FILL)
//   out_data/out_wr        registered byte + one-cycle strobe to the streamer
//   out_have_space         streamer has at least 8 free entries
//   busy                   arbiter is not idle
//   grant_id               current or most recent granted source
// -----------------------------------------------------------------------------
module usb_stream_arbiter #(
  parameter int         NUM_SRC      = 4,
  parameter int         MAX_BURST    = 64,
  parameter int         FILL_TIMEOUT = 256,
  parameter logic [3:0] HDR_TAG      = usb_arb_pkg::HDR_TAG
) (
  input  logic                 mclk,
  input  logic                 reset,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic [7:0]           out_data,
  output logic                 out_wr,
  input  logic                 out_have_space,
  output logic                 busy,
  output logic [1:0]           grant_id
);
  import usb_arb_pkg::*;

  localparam int               AW         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [7:0]       BURST_FULL = 8'(MAX_BURST);
  localparam logic [15:0]      TIMEOUT    = 16'(FILL_TIMEOUT);
  localparam logic [NUM_SRC-1:0] SRC_ONE  = NUM_SRC'(1);

  arb_state_e state_q, state_d;

  logic [1:0]         rr_ptr;
  logic [7:0]         count_q;
  logic [15:0]        timer_q;
  logic [15:0]        timer_inc;
  logic               last_flag;
  logic [7:0]         emit_idx;
  logic [1:0]         pick_id;
  logic               any_valid;
  logic [NUM_SRC-1:0] grant_mask;
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;
  logic               accept;
  logic               emit_fire;
  logic [7:0]         emit_byte;
  logic               frame_done;
  logic [1:0]         next_rr;
  logic [7:0]         chunk_buf [MAX_BURST];
`ifdef USB_ARB_CSUM_EN
  logic [7:0]         csum_q;
`endif

  usb_arb_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .valid     (src_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick_id),
    .any_valid (any_valid)
  );

  // Granted-source view of the input streams.
  assign grant_mask = SRC_ONE << grant_id;
  assign sel_valid  = |(src_valid & grant_mask);
  assign sel_last   = |(src_last & grant_mask);
  assign timer_inc  = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
  assign next_rr    = (grant_id == 2'(NUM_SRC - 1)) ? 2'd0 : grant_id + 2'd1;
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    sel_data = 8'h00;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id == 2'(i)) sel_data = src_data[8*i +: 8];
    end
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the values from before this edge.
  always_ff @(posedge mclk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state, ready and emit-slot decode. Emit states only fire a slot when
  // the streamer reports space, so a stalled byte is simply re-offered.
  always_comb begin
    state_d    = state_q;
    src_ready  = '0;
    accept     = 1'b0;
    emit_fire  = 1'b0;
    emit_byte  = 8'h00;
    frame_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_valid) state_d = ST_FILL;
      end
      ST_FILL: begin
        src_ready = grant_mask;
        accept    = sel_valid;
        if (accept) begin
          if (sel_last || (count_q + 8'd1 == BURST_FULL)) state_d = ST_HDR0;
        end else if ((timer_inc >= TIMEOUT) && (count_q != 8'd0)) begin
          state_d = ST_HDR0;
        end
      end
      ST_HDR0: begin
        if (out_have_space) begin
          emit_fire = 1'b1;
          emit_byte = make_hdr0(HDR_TAG, last_flag, grant_id);
          state_d   = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (out_have_space) begin
          emit_fire = 1'b1;
          emit_byte = count_q;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (out_have_space) begin
          emit_fire = 1'b1;
          emit_byte = chunk_buf[emit_idx[AW-1:0]];
          if (emit_idx == count_q - 8'd1) begin
`ifdef USB_ARB_CSUM_EN
            state_d = ST_CSUM;
`else
            state_d    = ST_IDLE;
            frame_done = 1'b1;
`endif
          end
        end
      end
`ifdef USB_ARB_CSUM_EN
      ST_CSUM: begin
        if (out_have_space) begin
          emit_fire  = 1'b1;
          emit_byte  = csum_q;
          state_d    = ST_IDLE;
          frame_done = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers. The strobe lags its slot by one cycle, which the
  // 8-entry have_space margin covers; a slot never fires in IDLE or FILL.
  always_ff @(posedge mclk) begin
    if (reset) begin
      out_wr    <= 1'b0;
      out_data  <= 8'h00;
      grant_id  <= 2'd0;
      rr_ptr    <= 2'd0;
      count_q   <= 8'd0;
      timer_q   <= 16'd0;
      last_flag <= 1'b0;
      emit_idx  <= 8'd0;
`ifdef USB_ARB_CSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      out_wr <= emit_fire;
      if (emit_fire)  out_data <= emit_byte;
      if (frame_done) rr_ptr   <= next_rr;
      unique case (state_q)
        ST_IDLE: begin
          count_q   <= 8'd0;
          timer_q   <= 16'd0;
          last_flag <= 1'b0;
          emit_idx  <= 8'd0;
`ifdef USB_ARB_CSUM_EN
          csum_q    <= 8'h00;
`endif
          if (any_valid) grant_id <= pick_id;
        end
        ST_FILL: begin
          if (accept) begin
            count_q   <= count_q + 8'd1;
            timer_q   <= 16'd0;
            last_flag <= sel_last;
`ifdef USB_ARB_CSUM_EN
            csum_q    <= csum_q ^ sel_data;
`endif
          end else begin
            timer_q <= timer_inc;
          end
        end
        ST_DATA: begin
          if (emit_fire) emit_idx <= emit_idx + 8'd1;
        end
`ifdef USB_ARB_CSUM_EN
        ST_HDR0, ST_HDR1: begin
          if (emit_fire) csum_q <= csum_q ^ emit_byte;
        end
`endif
        default: ;
      endcase
    end
  end

  // NOTE: the chunk buffer is deliberately left out of reset; count gates
  // which entries are ever read, so stale contents are harmless and the
  // array can map onto plain RAM.
  always_ff @(posedge mclk) begin
    if (accept) chunk_buf[count_q[AW-1:0]] <= sel_data;
  end

endmodule

// File: tb/tb_usb_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_usb_stream_arbiter
// Directed bench for usb_stream_arbiter (NUM_SRC=4, MAX_BURST=16,
// FILL_TIMEOUT=32). Expected frames are built from hand-chosen payloads;
// checksum bytes are appended when USB_ARB_CSUM_EN is defined.
// -----------------------------------------------------------------------------
module tb_usb_stream_arbiter;
  import usb_arb_pkg::*;

  localparam int NUM_SRC      = 4;
  localparam int MAX_BURST    = 16;
  localparam int FILL_TIMEOUT = 32;

  logic                 mclk = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_SRC-1:0]   src_valid = '0;
  logic [8*NUM_SRC-1:0] src_data = '0;
  logic [NUM_SRC-1:0]   src_last = '0;
  logic [NUM_SRC-1:0]   src_ready;
  logic [7:0]           out_data;
  logic                 out_wr;
  logic                 out_have_space = 1'b1;
  logic                 busy;
  logic [1:0]           grant_id;

  usb_stream_arbiter #(
    .NUM_SRC      (NUM_SRC),
    .MAX_BURST    (MAX_BURST),
    .FILL_TIMEOUT (FILL_TIMEOUT),
    .HDR_TAG      (4'hA)
  ) dut (
    .mclk           (mclk),
    .reset          (reset),
    .src_valid      (src_valid),
    .src_data       (src_data),
    .src_last       (src_last),
    .src_ready      (src_ready),
    .out_data       (out_data),
    .out_wr         (out_wr),
    .out_have_space (out_have_space),
    .busy           (busy),
    .grant_id       (grant_id)
  );

  always #5 mclk = ~mclk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pl_q[$];
  int         grant_q[$];
  logic [NUM_SRC-1:0] rdy_prev = '0;

  // Capture every strobed byte and every FILL entry (ready rising).
  always @(negedge mclk) begin
    if (out_wr === 1'b1) got_q.push_back(out_data);
    if (src_ready != '0 && rdy_prev == '0) grant_q.push_back(int'(grant_id));
    rdy_prev = src_ready;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic add_pl(input int n, input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < n; i++) pl_q.push_back(base + 8'(i) * step);
  endtask

  // Append one expected frame built from pl_q, then clear pl_q.
  task automatic push_frame(input int id, input bit last);
    logic [7:0] h0;
    logic [7:0] h1;
    h0 = {4'hA, last, 1'b0, 2'(id)};
    h1 = 8'(pl_q.size());
    exp_q.push_back(h0);
    exp_q.push_back(h1);
    foreach (pl_q[i]) exp_q.push_back(pl_q[i]);
`ifdef USB_ARB_CSUM_EN
    begin
      logic [7:0] cs;
      cs = h0 ^ h1;
      foreach (pl_q[i]) cs ^= pl_q[i];
      exp_q.push_back(cs);
    end
`endif
    pl_q.delete();
  endtask

  task automatic expect_stream(input string tag);
    int budget;
    budget = 3000;
    while ((got_q.size() < exp_q.size() || busy) && budget > 0) begin
      @(negedge mclk);
      budget--;
    end
    repeat (4) @(negedge mclk);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // last_mode: 0 = never, 1 = on the final byte, 2 = on every byte.
  task automatic send(input int s, input int n, input logic [7:0] base,
                      input logic [7:0] step, input int last_mode);
    int acc;
    int budget;
    acc    = 0;
    budget = 4000;
    for (int i = 0; i < n; i++) begin
      src_valid[s]         = 1'b1;
      src_data[8*s +: 8]   = base + 8'(i) * step;
      src_last[s]          = (last_mode == 2) || (last_mode == 1 && i == n - 1);
      while (!src_ready[s] && budget > 0) begin
        @(negedge mclk);
        budget--;
      end
      if (budget == 0) break;
      @(negedge mclk);
      acc++;
    end
    src_valid[s] = 1'b0;
    src_last[s]  = 1'b0;
    check($sformatf("send%0d_accepted", s), acc, n);
  endtask

  task automatic reset_dut();
    reset          = 1'b1;
    src_valid      = '0;
    src_last       = '0;
    out_have_space = 1'b1;
    repeat (2) @(negedge mclk);
    reset = 1'b0;
    got_q.delete();
    grant_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int budget;
    int acc;

    // Reset state.
    repeat (2) @(negedge mclk);
    check("rst_busy", busy, 0);
    check("rst_ready", src_ready, 0);
    check("rst_wr", out_wr, 0);
    check("rst_data", out_data, 0);
    check("rst_grant", grant_id, 0);
    reset = 1'b0;

    // 1: three-byte message from src0.
    reset_dut();
    send(0, 3, 8'h11, 8'h11, 1);
    add_pl(3, 8'h11, 8'h11);
    push_frame(0, 1'b1);
    expect_stream("t1");

    // 2: 20-byte message from src1 splits at MAX_BURST.
    reset_dut();
    send(1, 20, 8'h80, 8'h01, 1);
    add_pl(16, 8'h80, 8'h01);
    push_frame(1, 1'b0);
    add_pl(4, 8'h90, 8'h01);
    push_frame(1, 1'b1);
    expect_stream("t2");

    // 3: src3 stalls after two bytes; flushed after FILL_TIMEOUT idle cycles.
    reset_dut();
    send(3, 2, 8'h31, 8'h01, 0);
    cnt    = 0;
    budget = 200;
    while (src_ready[3] && budget > 0) begin
      cnt++;
      @(negedge mclk);
      budget--;
    end
    check("t3_ready_cycles", cnt, FILL_TIMEOUT);
    check("t3_ready_drop", src_ready[3], 0);
    add_pl(2, 8'h31, 8'h01);
    push_frame(3, 1'b0);
    expect_stream("t3");

    // 4: all sources valid with one-byte messages: rotation 0,1,2,3,0.
    reset_dut();
    fork
      send(0, 2, 8'h40, 8'h04, 2);
      send(1, 1, 8'h41, 8'h00, 2);
      send(2, 1, 8'h42, 8'h00, 2);
      send(3, 1, 8'h43, 8'h00, 2);
    join
    for (int s = 0; s < 4; s++) begin
      add_pl(1, 8'h40 + 8'(s), 8'h00);
      push_frame(s, 1'b1);
    end
    add_pl(1, 8'h44, 8'h00);
    push_frame(0, 1'b1);
    expect_stream("t4");
    check("t4_grants", grant_q.size(), 5);
    for (int i = 0; i < 5 && i < grant_q.size(); i++)
      check($sformatf("t4_grant%0d", i), grant_q[i], i % 4);

    // 5: streamer back-pressure for 10 cycles mid-payload.
    reset_dut();
    fork
      send(2, 12, 8'hC0, 8'h01, 1);
      begin
        budget = 500;
        while (got_q.size() < HDR_LEN + 4 && budget > 0) begin
          @(negedge mclk);
          budget--;
        end
        out_have_space = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge mclk);
          check($sformatf("t5_wr_low%0d", i), out_wr, 0);
        end
        out_have_space = 1'b1;
      end
    join
    add_pl(12, 8'hC0, 8'h01);
    push_frame(2, 1'b1);
    expect_stream("t5");

    // 6: reset after 5 accepts in FILL discards the chunk and rr_ptr.
    reset_dut();
    send(2, 1, 8'h5A, 8'h00, 1);
    add_pl(1, 8'h5A, 8'h00);
    push_frame(2, 1'b1);
    expect_stream("t6a");
    acc    = 0;
    budget = 200;
    src_valid[2]     = 1'b1;
    src_data[23:16]  = 8'hD0;
    while (acc < 5 && budget > 0) begin
      cnt = int'(src_ready[2]);
      @(negedge mclk);
      budget--;
      if (cnt != 0) begin
        acc++;
        src_data[23:16] = 8'hD0 + 8'(acc);
      end
    end
    check("t6_accepts", acc, 5);
    reset     = 1'b1;
    src_valid = '0;
    @(negedge mclk);
    check("t6_busy", busy, 0);
    check("t6_ready", src_ready, 0);
    check("t6_wr", out_wr, 0);
    check("t6_grant", grant_id, 0);
    check("t6_no_output", got_q.size(), 0);
    reset = 1'b0;
    grant_q.delete();
    fork
      send(1, 1, 8'h61, 8'h00, 2);
      send(3, 1, 8'h63, 8'h00, 2);
    join
    add_pl(1, 8'h61, 8'h00);
    push_frame(1, 1'b1);
    add_pl(1, 8'h63, 8'h00);
    push_frame(3, 1'b1);
    expect_stream("t6b");
    check("t6_grants", grant_q.size(), 2);
    if (grant_q.size() >= 2) begin
      check("t6_grant_first", grant_q[0], 1);
      check("t6_grant_second", grant_q[1], 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_stream_arbiter.md
Name: usb_stream_arbiter

Overview:
- Shares the single USB byte-stream FIFO sink (data/wr/have_space) between up to 4 byte-stream sources.
- Grants one source at a time, round-robin, and collects up to MAX_BURST bytes into a local chunk buffer.
- Emits each chunk as a framed packet: a 2-byte header, then the payload (plus an optional checksum), so the host can demultiplex.
- Sits between the capture/sniffer front-ends and the USB streamer FIFO.

Parameters:
- NUM_SRC, 4: number of requesters, 1..4.
- MAX_BURST, 64: maximum payload bytes per chunk, 1..255.
- FILL_TIMEOUT, 256: idle cycles tolerated in FILL before a partial chunk is flushed, 1..65535.
- HDR_TAG, 4'hA: upper nibble of header byte 0.

Ports:
- mclk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- src_valid  in  NUM_SRC  per-source byte valid.
- src_data  in  8*NUM_SRC  per-source byte; source i occupies bits [8i+7:8i].
- src_last  in  NUM_SRC  marks the last byte of a source message.
- src_ready  out  NUM_SRC  byte accepted when valid&ready.
- out_data  out  8  byte to the streamer FIFO.
- out_wr  out  1  one-cycle write strobe to the streamer.
- out_have_space  in  1  streamer has at least 8 free entries.
- busy  out  1  state != IDLE.
- grant_id  out  2  currently or last granted source.

Behaviour:
- Clocking and reset:
  - Single clock mclk; reset is synchronous and active-high, named reset.
  - On reset: state=IDLE, src_ready=0, out_wr=0, out_data=0, busy=0, grant_id=0, rr_ptr=0, count=0, timer=0.
  - Reset mid-chunk discards buffered bytes; no partial frame is emitted.
- States: IDLE, FILL, HDR0, HDR1, DATA, CSUM (CSUM exists only with the optional feature).
- IDLE:
  - If any src_valid is high, grant the first valid index searching from rr_ptr upward with wrap.
  - Latch grant_id and go to FILL next cycle.
  - count=0; the checksum accumulator is cleared.
- FILL:
  - src_ready[grant_id]=1, combinational from state; all other src_ready bits are 0.
  - Each accept writes buf[count] and increments count.
  - Leave FILL for HDR0 on any of:
    - accepted byte has src_last=1 (last_flag=1);
    - count reaches MAX_BURST on this accept (last_flag=0);
    - timer reaches FILL_TIMEOUT with count>0 (last_flag=0).
  - timer resets on every accept and increments when src_valid[grant_id]=0.
  - A src_last accept that coincides with reaching MAX_BURST gives last_flag=1.
- HDR0 / HDR1 / DATA / CSUM: one byte per emit slot.
  - A slot fires only in a cycle where out_have_space=1; it registers out_data and sets out_wr=1 in the next cycle.
  - Otherwise out_wr=0 and the byte is held; nothing is lost or duplicated.
  - The 8-entry have_space margin absorbs the 1-cycle strobe latency.
- Frame contents:
  - Header byte 0 = {HDR_TAG, last_flag, 1'b0, grant_id}.
  - Header byte 1 = count, 1..MAX_BURST.
  - DATA emits buf[0..count-1] in order.
- End of frame: after the final byte, set rr_ptr = grant_id+1 mod NUM_SRC and go to IDLE.
  - A new grant is possible the cycle after.
  - A source streaming longer than MAX_BURST is re-granted only after higher-rotation sources get a turn.
- Widths: count is 8 bits; timer is 16 bits and saturates.
- out_wr is never asserted in IDLE or FILL.

Optional Feature:
- USB_ARB_CSUM_EN:
  - Defined: after DATA, emit one CSUM byte = XOR of header bytes 0 and 1 and all payload bytes, under the same have_space rule.
  - Undefined: the CSUM state and accumulator are absent; the frame ends after the last payload byte.

Decomposition:
- Shared package usb_arb_pkg holds:
  - the state enum;
  - HDR_TAG;
  - header field positions (tag [7:4], last [3], id [1:0]);
  - the frame-length helper constant HDR_LEN=2.
- One natural sub-module, usb_arb_rr_pick: combinational round-robin selector (valid vector, rr_ptr in; grant index and any-valid out).
- Chunk buffer and FSM stay in the top level.

Test Plan:
- Src0 sends 0x11, 0x22, 0x33 with last on 0x33, out_have_space=1.
  - Required: out stream A8 03 11 22 33; with CSUM_EN, AB follows.
- MAX_BURST=16; src1 alone sends 20 bytes with last on byte 20.
  - Required: A1 10 + 16 bytes, then A9 04 + 4 bytes.
- FILL_TIMEOUT=32; src3 sends 2 bytes then holds valid low.
  - Required: after 32 idle cycles, A3 02 + 2 bytes; src_ready[3] drops.
- All 4 sources continuously valid with 1-byte last messages.
  - Required: grant order 0, 1, 2, 3, 0.
  - Required: headers A8, A9, AA, AB, A8.
- out_have_space forced low for 10 cycles in the middle of DATA.
  - Required: out_wr=0 throughout.
  - Required: the payload resumes at the exact next byte, with no gaps or repeats in sequence.
- reset pulsed for 1 cycle during FILL after 5 accepts.
  - Required: next cycle is IDLE, out_wr=0, src_ready=0.
  - Required: the next frame starts from count 0 with rr_ptr=0.
